ascon_fsm: RTL and testbench

Control state machine for the Ascon-128 AEAD permutation datapath. It sits directly upstream of the permutation/XOR datapath and drives every datapath control input:
- input mux select
- round-counter init and enable
- XOR-up and XOR-down enables
- state, cipher and tag register enables

It sequences initialisation (p12), associated-data absorption (p6), plaintext encryption (p6) and finalisation (p12). It exchanges a valid/ready block handshake with the data source.

---
 rtl/ascon_fsm.sv | 176 +++++++++++++++++
 tb/tb_ascon_fsm.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_fsm.sv
// Control sequencer for the Ascon-128 permutation datapath: runs p12 init,
// p6 AD absorption, p6 plaintext encryption and p12 finalisation.
module ascon_fsm #(
  parameter logic [3:0] ROUND_LAST = 4'd11
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       block_valid_i,
  input  logic       block_last_i,
  input  logic [3:0] round_i,
  output logic       input_select_o,
  output logic       ena_cpt_o,
  output logic       init_a_o,
  output logic       init_b_o,
  output logic       ena_xor_up_o,
  output logic       ena_xor_down_o,
  output logic       down_sel_o,
  output logic       fin_key_o,
  output logic       ena_reg_state_o,
  output logic       ena_cipher_o,
  output logic       ena_tag_o,
  output logic       block_ready_o,
  output logic       cipher_valid_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CONF_INIT,
    S_INIT,
    S_AD_WAIT,
    S_AD,
    S_PT_WAIT,
    S_PT,
    S_FIN,
    S_DONE
  } state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   cipher_valid_q, cipher_valid_d;
  logic   round_last;
  logic   round_first;

  assign round_last  = (round_i == ROUND_LAST);
  assign round_first = (round_i == '0);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      last_q         <= 1'b0;
      cipher_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      cipher_valid_q <= cipher_valid_d;
    end
  end

  // The AD "last" flag is captured at acceptance; block_last_i is don't-care
  // while the p6 rounds run.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE:      if (start_i) state_d = S_CONF_INIT;
      S_CONF_INIT: state_d = S_INIT;
      S_INIT:      if (round_last) state_d = S_AD_WAIT;
      S_AD_WAIT: begin
        if (block_valid_i) begin
          last_d  = block_last_i;
          state_d = S_AD;
        end
      end
      S_AD:        if (round_last) state_d = last_q ? S_PT_WAIT : S_AD_WAIT;
      S_PT_WAIT:   if (block_valid_i) state_d = block_last_i ? S_FIN : S_PT;
      S_PT:        if (round_last) state_d = S_PT_WAIT;
      S_FIN:       if (round_last) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    input_select_o  = 1'b0;
    ena_cpt_o       = 1'b0;
    init_a_o        = 1'b0;
    init_b_o        = 1'b0;
    ena_xor_up_o    = 1'b0;
    ena_xor_down_o  = 1'b0;
    down_sel_o      = 1'b0;
    fin_key_o       = 1'b0;
    ena_reg_state_o = 1'b0;
    ena_cipher_o    = 1'b0;
    ena_tag_o       = 1'b0;
    block_ready_o   = 1'b0;
    done_o          = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_CONF_INIT: begin
        init_a_o  = 1'b1;
        ena_cpt_o = 1'b1;
      end
      S_INIT: begin
        ena_reg_state_o = 1'b1;
        ena_cpt_o       = 1'b1;
        input_select_o  = !round_first;
        if (round_last) begin
          ena_xor_down_o = 1'b1;
          init_b_o       = 1'b1;
        end
      end
      S_AD_WAIT: begin
        block_ready_o = 1'b1;
        if (block_valid_i) begin
          ena_xor_up_o    = 1'b1;
          ena_reg_state_o = 1'b1;
          ena_cpt_o       = 1'b1;
          input_select_o  = 1'b1;
        end
      end
      S_AD, S_PT: begin
        ena_reg_state_o = 1'b1;
        ena_cpt_o       = 1'b1;
        input_select_o  = 1'b1;
        if (round_last) begin
          init_b_o = 1'b1;
          if (state_q == S_AD && last_q) begin
            ena_xor_down_o = 1'b1;
            down_sel_o     = 1'b1;
          end
        end
      end
      S_PT_WAIT: begin
        // The last plaintext block is not taken here: it stays on the bus and
        // is absorbed in the first FIN cycle after the counter reloads to 0.
        block_ready_o = !(block_valid_i && block_last_i);
        if (block_valid_i && !block_last_i) begin
          ena_xor_up_o    = 1'b1;
          ena_cipher_o    = 1'b1;
          ena_reg_state_o = 1'b1;
          ena_cpt_o       = 1'b1;
          input_select_o  = 1'b1;
        end else if (block_valid_i) begin
          init_a_o  = 1'b1;
          ena_cpt_o = 1'b1;
        end
      end
      S_FIN: begin
        ena_reg_state_o = 1'b1;
        ena_cpt_o       = 1'b1;
        input_select_o  = 1'b1;
        if (round_first) begin
          block_ready_o = 1'b1;
          ena_xor_up_o  = 1'b1;
          ena_cipher_o  = 1'b1;
          fin_key_o     = 1'b1;
        end
        if (round_last) begin
          ena_xor_down_o = 1'b1;
          ena_tag_o      = 1'b1;
          init_b_o       = 1'b1;
        end
      end
      S_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

  assign cipher_valid_d = ena_cipher_o;
  assign cipher_valid_o = cipher_valid_q;
  assign busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_ascon_fsm.sv
// Bench for ascon_fsm: a planned transaction timeline feeds an event scoreboard;
// a datapath round counter closes the loop on round_i.
module tb_ascon_fsm;

  logic       clock_i, reset_i, start_i, block_valid_i, block_last_i;
  logic [3:0] round_i;
  logic input_select_o, ena_cpt_o, init_a_o, init_b_o, ena_xor_up_o;
  logic ena_xor_down_o, down_sel_o, fin_key_o, ena_reg_state_o, ena_cipher_o;
  logic ena_tag_o, block_ready_o, cipher_valid_o, busy_o, done_o;

  ascon_fsm #(.ROUND_LAST(4'd11)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i),
    .block_valid_i(block_valid_i), .block_last_i(block_last_i), .round_i(round_i),
    .input_select_o(input_select_o), .ena_cpt_o(ena_cpt_o), .init_a_o(init_a_o),
    .init_b_o(init_b_o), .ena_xor_up_o(ena_xor_up_o), .ena_xor_down_o(ena_xor_down_o),
    .down_sel_o(down_sel_o), .fin_key_o(fin_key_o), .ena_reg_state_o(ena_reg_state_o),
    .ena_cipher_o(ena_cipher_o), .ena_tag_o(ena_tag_o), .block_ready_o(block_ready_o),
    .cipher_valid_o(cipher_valid_o), .busy_o(busy_o), .done_o(done_o)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  // Datapath round counter: load 0, load 6, or count.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)       round_i <= 4'd0;
    else if (init_a_o) round_i <= 4'd0;
    else if (init_b_o) round_i <= 4'd6;
    else if (ena_cpt_o) round_i <= round_i + 4'd1;
  end

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  localparam int N = 2048;
  localparam int E_ACCEPT = 0, E_XUP = 1, E_CIPH = 2, E_CVAL = 3, E_XDKEY = 4,
                 E_XDSEP = 5, E_INITA = 6, E_INITB = 7, E_FKEY = 8, E_TAG = 9,
                 E_DONE = 10, E_LOADEXT = 11;

  typedef struct { int cyc; logic [11:0] sig; } ev_t;

  bit          drv_start [N];
  bit          drv_valid [N];
  bit          drv_last  [N];
  bit          exp_busy  [N];
  logic [11:0] exp_sig   [N];
  ev_t         exp_q [$];

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  logic [14:0] all_outs;
  assign all_outs = {input_select_o, ena_cpt_o, init_a_o, init_b_o, ena_xor_up_o,
                     ena_xor_down_o, down_sel_o, fin_key_o, ena_reg_state_o,
                     ena_cipher_o, ena_tag_o, block_ready_o, cipher_valid_o,
                     busy_o, done_o};

  function automatic logic [11:0] observed();
    logic [11:0] s;
    s = '0;
    s[E_ACCEPT]  = block_ready_o & block_valid_i;
    s[E_XUP]     = ena_xor_up_o;
    s[E_CIPH]    = ena_cipher_o;
    s[E_CVAL]    = cipher_valid_o;
    s[E_XDKEY]   = ena_xor_down_o & !down_sel_o;
    s[E_XDSEP]   = ena_xor_down_o & down_sel_o;
    s[E_INITA]   = init_a_o;
    s[E_INITB]   = init_b_o;
    s[E_FKEY]    = fin_key_o;
    s[E_TAG]     = ena_tag_o;
    s[E_DONE]    = done_o;
    s[E_LOADEXT] = ena_reg_state_o & !input_select_o;
    return s;
  endfunction

  function automatic int gap_for(int mode, bit is_ad, int idx);
    if (mode == 0) return 0;
    if (mode == 1) return (is_ad && idx == 0) ? 5 : 0;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic junk(input int from, input int to);
    for (int c = from; c <= to; c++) begin
      drv_valid[c] = 1'($urandom_range(0, 1));
      drv_last[c]  = 1'($urandom_range(0, 1));
    end
  endtask

  // Reference timeline: start at t, CONF_INIT t+1, p12 t+2..t+13, then each
  // block accepted at a runs p6 over a..a+5 and the wait state resumes at a+6.
  task automatic plan_txn(input int t, input int nad, input int npt, input int mode,
                          output int done_cyc);
    int w, a, l, g;
    drv_start[t] = 1'b1;
    exp_sig[t+1][E_INITA]   = 1'b1;
    exp_sig[t+2][E_LOADEXT] = 1'b1;
    exp_sig[t+13][E_XDKEY]  = 1'b1;
    exp_sig[t+13][E_INITB]  = 1'b1;
    junk(t + 1, t + 13);
    w = t + 14;
    for (int i = 0; i < nad; i++) begin
      g = gap_for(mode, 1'b1, i);
      a = w + g;
      drv_valid[a] = 1'b1;
      drv_last[a]  = (i == nad - 1);
      exp_sig[a][E_ACCEPT] = 1'b1;
      exp_sig[a][E_XUP]    = 1'b1;
      exp_sig[a+5][E_INITB] = 1'b1;
      if (i == nad - 1) exp_sig[a+5][E_XDSEP] = 1'b1;
      junk(a + 1, a + 5);
      w = a + 6;
    end
    drv_start[w] = 1'b1;
    for (int j = 0; j < npt - 1; j++) begin
      g = gap_for(mode, 1'b0, j);
      a = w + g;
      drv_valid[a] = 1'b1;
      drv_last[a]  = 1'b0;
      exp_sig[a][E_ACCEPT] = 1'b1;
      exp_sig[a][E_XUP]    = 1'b1;
      exp_sig[a][E_CIPH]   = 1'b1;
      exp_sig[a+1][E_CVAL] = 1'b1;
      exp_sig[a+5][E_INITB] = 1'b1;
      junk(a + 1, a + 5);
      w = a + 6;
    end
    l = w + gap_for(mode, 1'b0, npt - 1);
    drv_valid[l] = 1'b1; drv_last[l] = 1'b1;
    junk(l + 2, l + 13);
    drv_valid[l+1] = 1'b1; drv_last[l+1] = 1'b1;
    exp_sig[l][E_INITA]    = 1'b1;
    exp_sig[l+1][E_ACCEPT] = 1'b1;
    exp_sig[l+1][E_XUP]    = 1'b1;
    exp_sig[l+1][E_CIPH]   = 1'b1;
    exp_sig[l+1][E_FKEY]   = 1'b1;
    exp_sig[l+2][E_CVAL]   = 1'b1;
    exp_sig[l+12][E_XDKEY] = 1'b1;
    exp_sig[l+12][E_TAG]   = 1'b1;
    exp_sig[l+12][E_INITB] = 1'b1;
    exp_sig[l+13][E_DONE]  = 1'b1;
    for (int c = t + 1; c <= l + 13; c++) begin
      exp_busy[c] = 1'b1;
      if (c != w && $urandom_range(0, 3) == 0) drv_start[c] = 1'b1;
    end
    done_cyc = l + 13;
  endtask

  // Monitor: busy window every cycle, event signatures popped from the scoreboard.
  always @(negedge clock_i) begin
    logic [11:0] s;
    ev_t e;
    if (mon_en && cyc < N) begin
      checks++;
      if (busy_o !== exp_busy[cyc]) begin
        failures++;
        $display("FAIL busy cyc=%0d actual=%b required=%b", cyc, busy_o, exp_busy[cyc]);
      end
      s = observed();
      if (s != '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event cyc=%0d actual sig=%h required none", cyc, s);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.sig != s) begin
            failures++;
            $display("FAIL event actual cyc=%0d sig=%h required cyc=%0d sig=%h",
                     cyc, s, e.cyc, e.sig);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, d, end_cyc, k;
    reset_i = 1'b1; start_i = 1'b0; block_valid_i = 1'b0; block_last_i = 1'b0;
    for (int c = 0; c < N; c++) exp_sig[c] = '0;

    t = 5;
    plan_txn(t, 1, 1, 0, d);  t = d + 1 + int'($urandom_range(0, 3));
    plan_txn(t, 1, 1, 1, d);  t = d + 1 + int'($urandom_range(0, 3));
    plan_txn(t, 1, 3, 0, d);  t = d + 1 + int'($urandom_range(0, 3));
    plan_txn(t, 2, 1, 0, d);
    for (int r = 0; r < 6; r++) begin
      t = d + 1 + int'($urandom_range(0, 3));
      plan_txn(t, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), 2, d);
    end
    end_cyc = d;
    for (int c = 0; c <= end_cyc; c++)
      if (exp_sig[c] != '0) exp_q.push_back('{cyc: c, sig: exp_sig[c]});

    while (cyc <= end_cyc + 3) begin
      @(posedge clock_i); #1;
      if (cyc == 2) reset_i = 1'b0;
      if (cyc == 3) mon_en = 1'b1;
      start_i       = drv_start[cyc];
      block_valid_i = drv_valid[cyc];
      block_last_i  = drv_last[cyc];
      if (cyc == 1) begin
        @(negedge clock_i);
        checks++;
        if (all_outs !== '0) begin
          failures++;
          $display("FAIL reset_outputs actual=%b required=0", all_outs);
        end
      end
    end
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events actual_left=%0d required=0", exp_q.size());
    end

    // Abort during AD round 8, then restart.
    start_i = 1'b1; block_valid_i = 1'b0;
    @(posedge clock_i); #1; start_i = 1'b0;
    k = 0;
    while (!block_ready_o && k < 40) begin
      @(posedge clock_i); #1; k++;
    end
    checks++;
    if (!block_ready_o) begin
      failures++;
      $display("FAIL ad_wait_reach actual=timeout required=block_ready");
    end
    block_valid_i = 1'b1; block_last_i = 1'b0;
    @(posedge clock_i); #1; block_valid_i = 1'b0;
    @(posedge clock_i); #1;
    checks++;
    if (round_i !== 4'd8 || !ena_reg_state_o) begin
      failures++;
      $display("FAIL ad_round8 actual round=%0d reg=%b required round=8 reg=1",
               round_i, ena_reg_state_o);
    end
    reset_i = 1'b1; #1;
    checks++;
    if (all_outs !== '0) begin
      failures++;
      $display("FAIL abort_outputs actual=%b required=0", all_outs);
    end
    @(posedge clock_i); #1; reset_i = 1'b0;
    @(posedge clock_i); #1;
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle actual busy=%b required=0", busy_o);
    end
    start_i = 1'b1;
    @(posedge clock_i); #1; start_i = 1'b0;
    checks++;
    if ({init_a_o, ena_cpt_o, busy_o, ena_reg_state_o} !== 4'b1110) begin
      failures++;
      $display("FAIL restart_conf_init actual=%b required=1110",
               {init_a_o, ena_cpt_o, busy_o, ena_reg_state_o});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
